// File: rtl/csr_cpuif_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------------------------+
// | csr_cpuif_arbiter_if : two-requester upstream bundle plus the shared downstream cpuif port |
// | Revision 1.0                                                                               |
// +-------------------------------------------------------------------------------------------+
interface csr_cpuif_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]              up_req_i;
   logic [1:0]              up_is_wr_i;
   logic [2*ADDR_WIDTH-1:0] up_addr_i;
   logic [2*DATA_WIDTH-1:0] up_wdata_i;
   logic [2*DATA_WIDTH-1:0] up_biten_i;
   logic [1:0]              up_ack_o;
   logic                    up_err_o;
   logic [DATA_WIDTH-1:0]   up_rdata_o;

   logic                    s_req_o;
   logic                    s_req_is_wr_o;
   logic [ADDR_WIDTH-1:0]   s_addr_o;
   logic [DATA_WIDTH-1:0]   s_wr_data_o;
   logic [DATA_WIDTH-1:0]   s_wr_biten_o;
   logic                    s_stall_wr_i;
   logic                    s_stall_rd_i;
   logic                    s_rd_ack_i;
   logic                    s_rd_err_i;
   logic [DATA_WIDTH-1:0]   s_rd_data_i;
   logic                    s_wr_ack_i;
   logic                    s_wr_err_i;

   // Arbiter side
   modport slave (
      input  up_req_i, up_is_wr_i, up_addr_i, up_wdata_i, up_biten_i,
      output up_ack_o, up_err_o, up_rdata_o,
      output s_req_o, s_req_is_wr_o, s_addr_o, s_wr_data_o, s_wr_biten_o,
      input  s_stall_wr_i, s_stall_rd_i, s_rd_ack_i, s_rd_err_i, s_rd_data_i,
      input  s_wr_ack_i, s_wr_err_i
   );

   // Environment side: requesters and the CSR block
   modport master (
      output up_req_i, up_is_wr_i, up_addr_i, up_wdata_i, up_biten_i,
      input  up_ack_o, up_err_o, up_rdata_o,
      input  s_req_o, s_req_is_wr_o, s_addr_o, s_wr_data_o, s_wr_biten_o,
      output s_stall_wr_i, s_stall_rd_i, s_rd_ack_i, s_rd_err_i, s_rd_data_i,
      output s_wr_ack_i, s_wr_err_i
   );
endinterface
`default_nettype wire

// File: rtl/csr_cpuif_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------------------------+
// | csr_cpuif_arbiter : round-robin share of one CSR cpuif port between two requesters         |
// | Optional watchdog: define CSR_ARB_TIMEOUT_EN.   Revision 1.0                               |
// +-------------------------------------------------------------------------------------------+
module csr_cpuif_arbiter #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire logic                 clk_i,
   input  wire logic                 rst_i,
   csr_cpuif_arbiter_if.slave        bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                 state;
   logic                   owner;
   logic                   last_gnt;
   logic                   cap_wr;
   logic [ADDR_WIDTH-1:0]  cap_addr;
   logic [DATA_WIDTH-1:0]  cap_wdata;
   logic [DATA_WIDTH-1:0]  cap_biten;
   logic                   req_q;
   logic [1:0]             ack_q;
   logic                   err_q;
   logic [DATA_WIDTH-1:0]  rdata_q;

   logic                   gnt;
   logic                   sel_wr;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic [DATA_WIDTH-1:0]  sel_biten;
   logic                   stall;
   logic                   match_ack;
   logic                   match_err;
   logic [DATA_WIDTH-1:0]  match_rdata;
   logic                   timeout;

   // With both requesting, the one that did not win last time goes next
   assign gnt       = (bus.up_req_i == 2'b11) ? ~last_gnt : bus.up_req_i[1];
   assign sel_wr    = bus.up_is_wr_i[gnt];
   assign sel_addr  = gnt ? bus.up_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.up_addr_i[ADDR_WIDTH-1:0];
   assign sel_wdata = gnt ? bus.up_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.up_wdata_i[DATA_WIDTH-1:0];
   assign sel_biten = gnt ? bus.up_biten_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.up_biten_i[DATA_WIDTH-1:0];

   assign stall       = cap_wr ? bus.s_stall_wr_i : bus.s_stall_rd_i;
   assign match_ack   = cap_wr ? bus.s_wr_ack_i   : bus.s_rd_ack_i;
   assign match_err   = cap_wr ? bus.s_wr_err_i   : bus.s_rd_err_i;
   assign match_rdata = cap_wr ? '0 : bus.s_rd_data_i;

`ifdef CSR_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Zero in the first ISSUE cycle, so the limit is hit on the TIMEOUT_CYCLES-th busy cycle
   always_ff @(posedge clk_i) begin
      if (rst_i || state == IDLE) begin
         tmo_cnt <= '0;
      end else if (state == ISSUE || state == WAIT) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign timeout = (state == ISSUE || state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last_gnt  <= 1'b1;
         cap_wr    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_biten <= '0;
         req_q     <= 1'b0;
         ack_q     <= 2'b00;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.up_req_i) begin
                  owner     <= gnt;
                  last_gnt  <= gnt;
                  cap_wr    <= sel_wr;
                  cap_addr  <= sel_addr;
                  cap_wdata <= sel_wdata;
                  cap_biten <= sel_biten;
                  req_q     <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               if (match_ack && (state == WAIT || !stall)) begin
                  req_q   <= 1'b0;
                  ack_q   <= owner ? 2'b10 : 2'b01;
                  err_q   <= match_err;
                  rdata_q <= match_rdata;
                  state   <= RESP;
               end else if (timeout) begin
                  req_q   <= 1'b0;
                  ack_q   <= owner ? 2'b10 : 2'b01;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state   <= RESP;
               end else if (state == ISSUE && !stall) begin
                  req_q <= 1'b0;
                  state <= WAIT;
               end
            end
            RESP: begin
               ack_q   <= 2'b00;
               err_q   <= 1'b0;
               rdata_q <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_req_o       = req_q;
   assign bus.s_req_is_wr_o = cap_wr;
   assign bus.s_addr_o      = cap_addr;
   assign bus.s_wr_data_o   = cap_wdata;
   assign bus.s_wr_biten_o  = cap_biten;
   assign bus.up_ack_o      = ack_q;
   assign bus.up_err_o      = err_q;
   assign bus.up_rdata_o    = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_csr_cpuif_arbiter.sv
`default_nettype none
// tb_csr_cpuif_arbiter : random requesters and CSR responder against a transaction-level model.
module tb_csr_cpuif_arbiter;
   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int TMO = 8;
`ifdef CSR_ARB_TIMEOUT_EN
   localparam int DLY_MAX = 10;
`else
   localparam int DLY_MAX = 4;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   csr_cpuif_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   csr_cpuif_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Requester state: a held request plus its fields
   bit          rq_act [2];
   int          rq_gap [2];
   logic        rq_wr  [2];
   logic [AW-1:0] rq_addr [2];
   logic [DW-1:0] rq_wd   [2];
   logic [DW-1:0] rq_be   [2];

   // Reference view of the shared port
   bit          m_free, m_issue, m_resp, m_owner, m_last, m_wr, m_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd, m_be, m_rd;
   int          m_age;
   bit          dn_wait, late_ack;
   int          dn_dly;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_free = 1; m_issue = 0; m_resp = 0; m_owner = 0; m_last = 1;
      m_wr = 0; m_err = 0; m_rd = '0; m_age = 0;
      dn_wait = 0; dn_dly = 0;
   endtask

   task automatic check_outputs();
      chk("s_req", 64'(bus.s_req_o), 64'(m_issue));
      if (m_issue) begin
         chk("s_is_wr", 64'(bus.s_req_is_wr_o), 64'(m_wr));
         chk("s_addr",  64'(bus.s_addr_o),      64'(m_addr));
         chk("s_wdata", 64'(bus.s_wr_data_o),   64'(m_wd));
         chk("s_biten", 64'(bus.s_wr_biten_o),  64'(m_be));
      end
      chk("up_ack",   64'(bus.up_ack_o),   m_resp ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
      chk("up_err",   64'(bus.up_err_o),   m_resp ? 64'(m_err) : 64'd0);
      chk("up_rdata", 64'(bus.up_rdata_o), m_resp ? 64'(m_rd) : 64'd0);
   endtask

   // One clock cycle: check what the DUT shows now, then choose this cycle's inputs.
   task automatic step(input bit allow_rst);
      bit stall_sel, match, tmo, in_txn, do_rst, g;
      stall_sel = 0; match = 0; tmo = 0;
      in_txn = m_issue || dn_wait;
      check_outputs();

      for (int n = 0; n < 2; n++) begin
         if (m_resp && m_owner == n[0]) begin
            rq_act[n] = 0;
            rq_gap[n] = $urandom_range(0, 3);
         end else if (!rq_act[n]) begin
            rq_wr[n]   = 1'($urandom);
            rq_addr[n] = AW'($urandom);
            rq_wd[n]   = $urandom;
            rq_be[n]   = $urandom;
            if (rq_gap[n] == 0) rq_act[n] = 1;
            else rq_gap[n]--;
         end
      end

      do_rst = allow_rst && ((dn_wait && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0);
      if (do_rst) begin
         rq_act[0] = 1;
         rq_act[1] = 1;
      end

      bus.s_stall_wr_i = ($urandom_range(0, 2) == 0);
      bus.s_stall_rd_i = ($urandom_range(0, 2) == 0);
      bus.s_rd_ack_i   = 0;
      bus.s_wr_ack_i   = 0;
      bus.s_rd_err_i   = ($urandom_range(0, 3) == 0);
      bus.s_wr_err_i   = ($urandom_range(0, 3) == 0);
      bus.s_rd_data_i  = $urandom;

      if (m_issue) begin
         stall_sel = m_wr ? bus.s_stall_wr_i : bus.s_stall_rd_i;
         if (!stall_sel) begin
            if ($urandom_range(0, 1) == 1) match = 1;
            else begin dn_wait = 1; dn_dly = $urandom_range(1, DLY_MAX); end
         end
      end else if (dn_wait) begin
         dn_dly--;
         if (dn_dly == 0) begin
            match = 1; dn_wait = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            if (m_wr) bus.s_rd_ack_i = 1; else bus.s_wr_ack_i = 1;
         end
      end else if (late_ack || $urandom_range(0, 7) == 0) begin
         bus.s_rd_ack_i = late_ack | 1'($urandom);
         bus.s_wr_ack_i = ~bus.s_rd_ack_i;
      end
      late_ack = 0;
      if (match) begin
         if (m_wr) bus.s_wr_ack_i = 1; else bus.s_rd_ack_i = 1;
      end
`ifdef CSR_ARB_TIMEOUT_EN
      if (in_txn && !match && m_age == TMO - 1) begin
         tmo = 1; dn_wait = 0;
      end
`endif

      rst              = do_rst;
      bus.up_req_i     = {rq_act[1], rq_act[0]};
      bus.up_is_wr_i   = {rq_wr[1], rq_wr[0]};
      bus.up_addr_i    = {rq_addr[1], rq_addr[0]};
      bus.up_wdata_i   = {rq_wd[1], rq_wd[0]};
      bus.up_biten_i   = {rq_be[1], rq_be[0]};

      if (do_rst) begin
         model_reset();
         late_ack = 1;
      end else begin
         if (match) begin
            m_err = m_wr ? bus.s_wr_err_i : bus.s_rd_err_i;
            m_rd  = m_wr ? '0 : bus.s_rd_data_i;
         end
         if (tmo) begin
            m_err = 1; m_rd = '0;
         end
         if (m_free && (rq_act[0] || rq_act[1])) begin
            g = (rq_act[0] && rq_act[1]) ? !m_last : rq_act[1];
            m_owner = g; m_last = g;
            m_wr = rq_wr[g]; m_addr = rq_addr[g]; m_wd = rq_wd[g]; m_be = rq_be[g];
            m_issue = 1; m_free = 0; m_age = 0;
         end else begin
            if (m_resp) m_free = 1;
            m_issue = m_issue && stall_sel && !tmo;
            if (in_txn) m_age++;
         end
         m_resp = match || tmo;
      end
   endtask

   initial begin
      total = 0; bad = 0;
      clk = 0; rst = 1; late_ack = 0;
      bus.up_req_i = '0; bus.up_is_wr_i = '0; bus.up_addr_i = '0;
      bus.up_wdata_i = '0; bus.up_biten_i = '0;
      bus.s_stall_wr_i = 0; bus.s_stall_rd_i = 0; bus.s_rd_ack_i = 0; bus.s_rd_err_i = 0;
      bus.s_rd_data_i = '0; bus.s_wr_ack_i = 0; bus.s_wr_err_i = 0;
      model_reset();
      for (int n = 0; n < 2; n++) begin rq_act[n] = 0; rq_gap[n] = 0; end

      repeat (3) @(negedge clk);
      chk("rst_s_req",  64'(bus.s_req_o), 64'd0);
      chk("rst_ack",    64'(bus.up_ack_o), 64'd0);
      chk("rst_err",    64'(bus.up_err_o), 64'd0);
      chk("rst_rdata",  64'(bus.up_rdata_o), 64'd0);
      chk("rst_addr",   64'(bus.s_addr_o), 64'd0);
      chk("rst_wdata",  64'(bus.s_wr_data_o), 64'd0);

      // Both requesters write straight out of reset; requester 0 must go first
      rq_act[0] = 1; rq_wr[0] = 1; rq_addr[0] = 12'h020; rq_wd[0] = 32'h1; rq_be[0] = '1;
      rq_act[1] = 1; rq_wr[1] = 1; rq_addr[1] = 12'h024; rq_wd[1] = 32'h2; rq_be[1] = '1;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         step(cyc > 40);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/csr_cpuif_arbiter.md
Name: csr_cpuif_arbiter

Overview:
- Shares the single I3CCSR cpuif port between two requesters.
  - Requester 0: the AHB slave interface.
  - Requester 1: an internal agent, e.g. recovery/DMA logic.
- Fair round-robin grant, one outstanding transaction at a time.
- Captures the winning request and sequences the downstream handshake (req, stall, ack).
- Returns the registered response only to the owner. Sits between the bus adapters and I3CCSR.

Parameters:
ADDR_WIDTH, 12, cpuif byte address width (matches I3CCSR_MIN_ADDR_WIDTH)
DATA_WIDTH, 32, cpuif data width
TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with CSR_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
up_req_i  in  2  per-requester request; held high with stable fields until that requester's ack
up_is_wr_i  in  2  per-requester write(1)/read(0)
up_addr_i  in  2*ADDR_WIDTH  per-requester address, requester n in slice n
up_wdata_i  in  2*DATA_WIDTH  per-requester write data
up_biten_i  in  2*DATA_WIDTH  per-requester write bit enables
up_ack_o  out  2  one-cycle response strobe to the owner
up_err_o  out  1  error qualifier, valid with up_ack_o
up_rdata_o  out  DATA_WIDTH  read data, valid with up_ack_o (0 for writes)
s_req_o  out  1  downstream request
s_req_is_wr_o  out  1  downstream write select
s_addr_o  out  ADDR_WIDTH  downstream address
s_wr_data_o  out  DATA_WIDTH  downstream write data
s_wr_biten_o  out  DATA_WIDTH  downstream bit enables
s_stall_wr_i  in  1  downstream write stall
s_stall_rd_i  in  1  downstream read stall
s_rd_ack_i  in  1  downstream read done
s_rd_err_i  in  1  downstream read error
s_rd_data_i  in  DATA_WIDTH  downstream read data
s_wr_ack_i  in  1  downstream write done
s_wr_err_i  in  1  downstream write error

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer last_gnt=1, so requester 0 wins first.
  - Capture registers cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any up_req_i bit is set, grant.
    - Single requester: grant it.
    - Both requesting: grant the one != last_gnt.
  - Latch is_wr, addr, wdata and biten of the grantee.
  - Set owner and last_gnt = grantee.
  - Go to ISSUE next cycle.
- ISSUE:
  - s_req_o=1 with latched fields.
  - stall = is_wr ? s_stall_wr_i : s_stall_rd_i.
  - stall=1: remain in ISSUE, fields unchanged.
  - stall=0 and matching ack in the same cycle: capture the response, go to RESP.
  - stall=0, no ack: go to WAIT.
- WAIT:
  - s_req_o=0.
  - On the matching ack (s_wr_ack_i if write, s_rd_ack_i if read), capture err and rdata (rdata forced 0 for writes), go to RESP.
  - Acks of the wrong type are ignored.
- RESP:
  - up_ack_o[owner]=1 for exactly one cycle, with up_err_o/up_rdata_o.
  - Then go to IDLE.
  - Outside RESP: up_ack_o=0, up_err_o=0, up_rdata_o=0.
- Latency: grant-to-ack = 3 cycles minimum with no stall and same-cycle ack. Each stall cycle or ack-wait cycle adds 1.
- The requester drops its req in the cycle after its ack. A req still high in the IDLE cycle after RESP is treated as a new request and arbitrated normally.
- Requester 0 held continuously while requester 1 also requests: grants strictly alternate, so neither is starved.
- A requester's req changing while it is not granted is ignored until IDLE.
- Synchronous reset mid-transaction: everything returns to the reset state next cycle. No ack is delivered for the aborted transaction, and any late downstream ack is ignored in IDLE.
- Downstream ack arriving in IDLE (spurious): ignored, no upstream ack.

Optional Feature:
- Macro: CSR_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - On reaching TIMEOUT_CYCLES without a matching ack, go to RESP with up_err_o=1, up_rdata_o=0, and drop s_req_o.
  - Any matching ack arriving later is ignored.
- Undefined: no counter; the arbiter waits indefinitely.

Test Plan:
- Single read:
  - Stimulus: requester 0 reads addr 0x010; downstream is unstalled and acks 1 cycle after req with data 0xDEADBEEF.
  - Response: up_ack_o=2'b01, up_rdata_o=0xDEADBEEF, up_err_o=0.
- Simultaneous requests from reset:
  - Stimulus: both requesters write (r0 addr 0x020 data 0x1, r1 addr 0x024 data 0x2), held until ack.
  - Response: downstream sees 0x020 first, then 0x024; acks go to r0 then r1.
- Stalled write:
  - Stimulus: r1 writes; s_stall_wr_i high for 3 cycles.
  - Response: s_req_o stays high 4 cycles with fields stable; a single up_ack_o[1] follows.
- Read error:
  - Stimulus: downstream returns s_rd_ack_i with s_rd_err_i=1.
  - Response: up_ack_o pulses for the owner with up_err_o=1.
- Reset mid-operation:
  - Stimulus: rst_i asserted in WAIT, then a late s_rd_ack_i.
  - Response: all outputs 0, no up_ack_o; r0 wins the next simultaneous request.
- Timeout (CSR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: no downstream ack.
  - Response: up_ack_o after 8 cycles in ISSUE/WAIT, with up_err_o=1 and up_rdata_o=0.
